// File: rtl/sram_responder.sv
// Responder end of a CPU SRAM-style port: one request per cycle, 1-cycle read latency,
// byte-enabled writes, an optional zero-fill after reset and a saturating out-of-window counter.
module sram_responder #(
   parameter int          ADDR_W     = 10,
   parameter logic [31:0] BASE       = 32'h0000_0000,
   parameter bit          INIT_CLEAR = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sram_en,
   input  logic [3:0]  sram_wen,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   output logic [31:0] sram_rdata,
   output logic        busy,
   output logic [7:0]  err_cnt
);

   localparam int   DEPTH    = 1 << ADDR_W;
   localparam logic ST_INIT  = 1'b0;
   localparam logic ST_RUN   = 1'b1;
   localparam logic ST_RESET = INIT_CLEAR ? ST_INIT : ST_RUN;

   logic [31:0]       mem [DEPTH];
   logic              state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [7:0]        err_q, err_d;

   logic              in_win;
   logic [ADDR_W-1:0] req_idx;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_widx;
   logic [31:0]       mem_wdata;
   logic              unused_addr_lsb;

   assign in_win          = (sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
   assign req_idx         = sram_addr[ADDR_W+1:2];
   assign unused_addr_lsb = ^sram_addr[1:0];

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      mem_we    = 4'b0000;
      mem_widx  = req_idx;
      mem_wdata = sram_wdata;
      if (state_q == ST_INIT) begin
         // Fill one word per cycle; any request arriving now is dropped.
         mem_we    = 4'b1111;
         mem_widx  = idx_q;
         mem_wdata = 32'h0;
         idx_d     = idx_q + ADDR_W'(1);
         if (idx_q == {ADDR_W{1'b1}}) begin
            state_d = ST_RUN;
         end
      end else if (sram_en) begin
         if (in_win) begin
            if (sram_wen == 4'b0000) begin
               rdata_d = mem[req_idx];
            end else begin
               mem_we = sram_wen;
            end
         end else begin
            if (sram_wen == 4'b0000) begin
               rdata_d = 32'h0;
            end
            if (err_q != 8'hFF) begin
               err_d = err_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_RESET;
         idx_q   <= '0;
         rdata_q <= 32'h0;
         err_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Array has no reset; writes are suppressed while reset is held so an aborted request is dropped.
   always_ff @(posedge clk) begin
      if (resetn) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) begin
               mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   assign sram_rdata = rdata_q;
   assign busy       = (state_q == ST_INIT);
   assign err_cnt    = err_q;

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_W, default 10: word-index width; DEPTH = 2^ADDR_W words.
REQ-002 Parameter BASE, default 32'h0000_0000: base byte address of the window; only bits [31:ADDR_W+2] are compared.
REQ-003 Parameter INIT_CLEAR, default 1: 1 = zero-fill the array after reset; 0 = skip the fill.
REQ-004 Clock and reset: one clock, clk; reset is asynchronous and active-low, resetn.
REQ-005 Port list:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- sram_en  in  1  request valid this cycle.
- sram_wen  in  4  byte write enables; bit i covers wdata[8i+7:8i]; 0 = read.
- sram_addr  in  32  byte address; bits [1:0] ignored.
- sram_wdata  in  32  write data.
- sram_rdata  out  32  read data, registered.
- busy  out  1  high while the zero-fill is in progress.
- err_cnt  out  8  saturating count of out-of-window requests.

Function
REQ-006 The block SHALL be the responder end of the CPU's SRAM-style port: single request per cycle, no handshake back-pressure.
REQ-007 The FSM SHALL have two states, INIT and RUN.
- INIT: write 32'h0 to word idx each cycle; idx increments from 0; busy=1.
- INIT -> RUN in the cycle after idx = DEPTH-1 is written; idx wraps to 0.
REQ-008 Requests (sram_en=1) during INIT SHALL be ignored: no write, sram_rdata held, err_cnt unchanged.
REQ-009 The request is in-window when sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]; the word index is sram_addr[ADDR_W+1:2].
REQ-010 Read (RUN, sram_en=1, sram_wen=4'b0, in-window): sram_rdata SHALL equal the addressed word on the cycle after the request; latency is exactly 1.
REQ-011 Write (RUN, sram_en=1, sram_wen!=0, in-window): only the enabled bytes SHALL update at the clock edge; the other bytes keep their old values; sram_rdata is held.
REQ-012 A read in cycle N+1 of a word written in cycle N SHALL return the merged new value, with no stale data.
REQ-013 An out-of-window request in RUN SHALL not modify the array.
- Read: sram_rdata = 32'h0 on the next cycle.
- Write: sram_rdata is held.
- Both: err_cnt increments by 1 and saturates at 8'hFF.
REQ-014 sram_en=0 SHALL hold sram_rdata and leave the array untouched, whatever sram_wen, sram_addr and sram_wdata are.
REQ-015 Back-to-back requests on consecutive cycles SHALL each be served with no bubble.
REQ-016 All outputs SHALL be registered; there is no combinational path from input to output.

Reset
REQ-017 While resetn=0 (asynchronous):
- sram_rdata = 32'h0, err_cnt = 8'h00, idx = 0.
- state = INIT and busy = 1 if INIT_CLEAR=1.
- state = RUN and busy = 0 if INIT_CLEAR=0.
REQ-018 Array contents SHALL not be reset directly; they are cleared only by the INIT fill.
REQ-019 Reset asserted mid-INIT SHALL restart the fill at idx 0 after release.
REQ-020 Reset asserted mid-RUN SHALL abort any request in that cycle; the array write at that edge is not guaranteed.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Fill: ADDR_W=4, INIT_CLEAR=1, release reset -> busy=1 for 16 cycles then 0; reads of words 0..15 return 32'h0.
- Byte merge: write 32'h11223344 wen=4'hF to addr 0x8, then 32'hAABBCCDD wen=4'b0101 to the same address, read next cycle -> rdata=32'h11BB33DD.
- Latency and back-to-back: writes to 0x0/0x4 = 32'hA/32'hB, then reads 0x0,0x4 on consecutive cycles -> rdata=A then B, one cycle after each request.
- Out-of-window: BASE=0, ADDR_W=4, read 0x0000_0040 -> rdata=0 and err_cnt=1; 300 such requests -> err_cnt=8'hFF.
- INIT ignore: write 32'hFFFF_FFFF wen=4'hF to 0x0 during INIT -> word 0 reads 32'h0 after INIT and err_cnt=0.
- Reset mid-INIT: drop resetn at idx=7 then release -> busy high for a full DEPTH cycles; rdata=0 during reset.
